// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Byte FIFO feeding an 8N1 UART transmitter with a registered line.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int CLK_DIV = 354,
    parameter int DEPTH   = 8
) (
    input  logic                     IO_CLK,
    input  logic                     IO_RST_N,
    input  logic                     wr_valid_i,
    input  logic [7:0]               wr_data_i,
    output logic                     wr_ready_o,
    output logic                     tx_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int              AW            = $clog2(DEPTH);
    localparam logic [1:0]      S_IDLE        = 2'd0;
    localparam logic [1:0]      S_START       = 2'd1;
    localparam logic [1:0]      S_DATA        = 2'd2;
    localparam logic [1:0]      S_STOP        = 2'd3;
    localparam logic [15:0]     C_BAUD_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [AW:0]     C_FULL        = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [1:0]    state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          push, pop, bit_end;

    assign wr_ready_o = (level_q != C_FULL);
    assign push       = wr_valid_i && wr_ready_o;
    assign bit_end    = (baud_q == 16'd0);
    // A pop only happens from IDLE or at the very end of a stop bit.
    assign pop        = (level_q != '0) &&
                        ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

    assign tx_o    = tx_q;
    assign level_o = level_q;
    assign busy_o  = (state_q != S_IDLE) || (level_q != '0);

    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

    always_ff @(posedge IO_CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pop)                     state_d = S_START;
            S_START: if (bit_end)                 state_d = S_DATA;
            S_DATA:  if (bit_end && bit_q == 3'd7) state_d = S_STOP;
            S_STOP:  if (bit_end)                 state_d = pop ? S_START : S_IDLE;
            default:                              state_d = S_IDLE;
        endcase
    end

    always_comb begin
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = C_BAUD_RELOAD;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                baud_d = bit_end ? C_BAUD_RELOAD : baud_q - 16'd1;
                if (bit_end) begin
                    bit_d = 3'd0;
                    tx_d  = shift_q[0];
                end
            end
            S_DATA: begin
                baud_d = bit_end ? C_BAUD_RELOAD : baud_q - 16'd1;
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        // Next bit is driven directly from the pre-shift value.
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_STOP: begin
                baud_d = bit_end ? C_BAUD_RELOAD : baud_q - 16'd1;
                if (bit_end) begin
                    if (pop) begin
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                    end else begin
                        tx_d    = 1'b1;
                    end
                end
            end
            default: tx_d = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Randomised scoreboard bench for uart_tx_fifo (CLK_DIV=4, DEPTH=8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    localparam int D     = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid_i = 1'b0;
    logic [7:0] wr_data_i = 8'h00;
    logic       wr_ready_o, tx_o, busy_o;
    logic [3:0] level_o;

    uart_tx_fifo #(.CLK_DIV(D), .DEPTH(DEPTH)) dut (
        .IO_CLK     (clk),
        .IO_RST_N   (rst_n),
        .wr_valid_i (wr_valid_i),
        .wr_data_i  (wr_data_i),
        .wr_ready_o (wr_ready_o),
        .tx_o       (tx_o),
        .busy_o     (busy_o),
        .level_o    (level_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: FIFO as a byte queue, the byte on the wire, and the
    // number of cycles left before the transmitter may take another byte.
    logic [7:0] m_q [$];
    logic [7:0] sb_q [$];
    logic [7:0] m_cur = 8'h00;
    int         m_rem = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    function automatic logic exp_tx();
        int idx;
        if (m_rem == 0) return 1'b1;
        idx = (FRAME - m_rem) / D;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_cur[idx-1];
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        sb_q.delete();
        m_rem = 0;
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        int  pre;
        logic acc, pop;
        wr_valid_i = v;
        wr_data_i  = d;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            pre = m_q.size();
            acc = v && (pre != DEPTH);
            if (m_rem > 0) m_rem--;
            pop = (m_rem == 0) && (pre > 0);
            if (pop) begin
                m_cur = m_q.pop_front();
                m_rem = FRAME;
            end
            if (acc) begin
                m_q.push_back(d);
                sb_q.push_back(d);
            end
        end
        #1;
    endtask

    task automatic drain(input int max_steps);
        int n = 0;
        while ((m_rem > 0 || m_q.size() > 0) && n < max_steps) begin
            step(1'b0, 8'h00);
            n++;
        end
        step(1'b0, 8'h00);
        chk("drain_busy", 32'(busy_o), 32'd0);
    endtask

    // Monitor: per-cycle comparison against the model plus a line decoder
    // that rebuilds bytes from tx_o and matches them against the scoreboard.
    initial begin
        bit         in_frame = 1'b0;
        int         cyc = 0;
        int         idx;
        logic [7:0] rx = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0;
                continue;
            end
            chk("tx_o",       32'(tx_o),       32'(exp_tx()));
            chk("level_o",    32'(level_o),    32'(m_q.size()));
            chk("wr_ready_o", 32'(wr_ready_o), 32'(m_q.size() != DEPTH));
            chk("busy_o",     32'(busy_o),     32'((m_rem > 0) || (m_q.size() > 0)));
            if (!in_frame) begin
                if (tx_o === 1'b0) begin
                    in_frame = 1'b1;
                    cyc = 0;
                end
            end else begin
                cyc++;
            end
            if (in_frame) begin
                if (cyc % D == D / 2) begin
                    idx = cyc / D;
                    if (idx >= 1 && idx <= 8) rx[idx-1] = tx_o;
                    else if (idx == 9) begin
                        chk("stop_bit", 32'(tx_o), 32'd1);
                        if (sb_q.size() == 0) chk("sb_frame_expected", 32'd0, 32'd1);
                        else chk("rx_byte", 32'(rx), 32'(sb_q.pop_front()));
                    end
                end
                if (cyc == FRAME - 1) in_frame = 1'b0;
            end
        end
    end

    initial begin
        int guard;
        logic [7:0] burst [10];

        // Reset state
        repeat (3) step(1'b0, 8'h00);
        chk("rst_tx",    32'(tx_o),       32'd1);
        chk("rst_busy",  32'(busy_o),     32'd0);
        chk("rst_level", 32'(level_o),    32'd0);
        chk("rst_ready", 32'(wr_ready_o), 32'd1);
        #1 rst_n = 1'b1;
        repeat (2) step(1'b0, 8'h00);

        // Single byte 0x55
        step(1'b1, 8'h55);
        step(1'b0, 8'h00);
        chk("start_low_k1", 32'(tx_o), 32'd0);
        drain(100);

        // Back-to-back 0xA3, 0x0F
        step(1'b1, 8'hA3);
        step(1'b1, 8'h0F);
        drain(200);

        // Burst of 10 writes, then hold valid high while full
        for (int i = 0; i < 10; i++) burst[i] = 8'($urandom);
        for (int i = 0; i < 10; i++) step(1'b1, burst[i]);
        chk("full_level", 32'(level_o), 32'd8);
        chk("full_ready", 32'(wr_ready_o), 32'd0);
        for (int i = 0; i < 90; i++) step(1'b1, 8'($urandom));
        drain(600);

        // Reset during data bit 3 of a frame
        step(1'b1, 8'hC6);
        step(1'b1, 8'h3B);
        guard = 0;
        while (!(m_rem >= FRAME - 5*D + 1 && m_rem <= FRAME - 4*D) && guard < 100) begin
            step(1'b0, 8'h00);
            guard++;
        end
        chk("reach_bit3", 32'(guard < 100), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_tx",    32'(tx_o),       32'd1);
        chk("abort_level", 32'(level_o),    32'd0);
        chk("abort_busy",  32'(busy_o),     32'd0);
        chk("abort_ready", 32'(wr_ready_o), 32'd1);
        model_reset();
        repeat (2) step(1'b0, 8'h00);
        #1 rst_n = 1'b1;
        repeat (60) step(1'b0, 8'h00);

        // Random traffic, many pointer wraps
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 11) == 0) step(1'b1, 8'($urandom));
            else                            step(1'b0, 8'h00);
        end
        drain(600);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
